// File: rtl/mtx_pkg.sv
// Shared definitions for the MAPU result collector.
//   MTX_NUM_CH_DEFAULT / MTX_DATA_WIDTH_DEFAULT : default channel count and word width
//   mtx_ch_id_t   : channel index type at the default channel count
//   mtx_entry_t   : packed FIFO entry {ch_id, data} at the default sizes
//   mtx_wrap_add  : modular add for channel indices (base and ofs both < n)
package mtx_pkg;

  localparam int MTX_NUM_CH_DEFAULT     = 32;
  localparam int MTX_DATA_WIDTH_DEFAULT = 32;
  localparam int MTX_CH_ID_W            = $clog2(MTX_NUM_CH_DEFAULT);

  typedef logic [MTX_CH_ID_W-1:0] mtx_ch_id_t;

  typedef struct packed {
    mtx_ch_id_t                        ch_id;
    logic [MTX_DATA_WIDTH_DEFAULT-1:0] data;
  } mtx_entry_t;

  // A single conditional subtract is enough because base and ofs are both
  // below n, so the sum never reaches 2n.
  function automatic int mtx_wrap_add(input int base, input int ofs, input int n);
    int s;
    s = base + ofs;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mtx_res_fifo.sv
// Two-entry FIFO holding collected {ch_id, data} entries.
//   clk, rst_n          : clock, synchronous active-low reset (control only)
//   push, push_data     : write request and entry; ignored when full
//   pop, pop_data       : read request; pop_data always shows the head entry
//   full, empty         : occupancy flags
module mtx_res_fifo
  import mtx_pkg::*;
#(
  parameter int ENTRY_W = $bits(mtx_entry_t)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] pop_data,
  output logic               full,
  output logic               empty
);

  logic [ENTRY_W-1:0] mem [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         cnt;
  logic               do_push;
  logic               do_pop;

  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mtx_res_collector.sv
// Collects results from NUM_CH MAPU channels into one output stream.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   test_mode_en       : 1 = fixed priority (ch0 highest), 0 = round-robin
//   ch_vld, ch_data    : per-channel result valid and packed result words
//   ch_rdy             : per-channel accept, one-hot or zero
//   out_vld, out_data, out_ch_id, out_rdy : collected result stream
//   res_cnt            : results delivered on the output since reset (wraps)
module mtx_res_collector
  import mtx_pkg::*;
#(
  parameter int NUM_CH     = MTX_NUM_CH_DEFAULT,
  parameter int DATA_WIDTH = MTX_DATA_WIDTH_DEFAULT
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst_n,
  input  logic                         test_mode_en,
  input  logic [NUM_CH-1:0]            ch_vld,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]            ch_rdy,
  output logic                         out_vld,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_ch_id,
  input  logic                         out_rdy,
  output logic [31:0]                  res_cnt
);

  localparam int CH_ID_W = $clog2(NUM_CH);
  localparam int ENTRY_W = CH_ID_W + DATA_WIDTH;

  logic [CH_ID_W-1:0] rr_ptr;
  logic [CH_ID_W-1:0] grant_id;
  logic               grant_vld;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  int                 idx;

  // Search order starts at rr_ptr in round-robin mode and at 0 in test mode;
  // the first requesting channel in that order wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = test_mode_en ? k : mtx_wrap_add(int'(rr_ptr), k, NUM_CH);
      if (!grant_vld && ch_vld[idx]) begin
        grant_vld = 1'b1;
        grant_id  = CH_ID_W'(idx);
      end
    end
  end

  // Accept depends only on FIFO occupancy, never on out_rdy, so a full FIFO
  // blocks input even in a cycle where the head is being drained.
  assign push = sys_rst_n && grant_vld && !fifo_full;

  always_comb begin
    ch_rdy = '0;
    if (push) ch_rdy[grant_id] = 1'b1;
  end

  assign push_entry = {grant_id, ch_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH]};

  mtx_res_fifo #(
    .ENTRY_W (ENTRY_W)
  ) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output fields read zero whenever nothing valid is presented.
  assign out_vld   = sys_rst_n && !fifo_empty;
  assign pop       = out_vld && out_rdy;
  assign out_data  = out_vld ? head_entry[DATA_WIDTH-1:0] : '0;
  assign out_ch_id = out_vld ? head_entry[ENTRY_W-1 -: CH_ID_W] : '0;

  // Pointer advances past the granted channel only on a round-robin accept.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rr_ptr <= '0;
    end else if (push && !test_mode_en) begin
      rr_ptr <= CH_ID_W'(mtx_wrap_add(int'(grant_id), 1, NUM_CH));
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      res_cnt <= '0;
    end else if (pop) begin
      res_cnt <= res_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mtx_res_collector.sv
module tb_mtx_res_collector;

  localparam int NCH = 4;
  localparam int DW  = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              test_mode_en;
  logic [NCH-1:0]    ch_vld;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_rdy;
  logic              out_vld;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch_id;
  logic              out_rdy;
  logic [31:0]       res_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] d;
  } ent_t;

  ent_t        mq[$];
  int          mptr = 0;
  logic [31:0] mcnt = 0;

  always #5 sys_clk = ~sys_clk;

  mtx_res_collector #(.NUM_CH(NCH), .DATA_WIDTH(DW)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .test_mode_en (test_mode_en),
    .ch_vld       (ch_vld),
    .ch_data      (ch_data),
    .ch_rdy       (ch_rdy),
    .out_vld      (out_vld),
    .out_data     (out_data),
    .out_ch_id    (out_ch_id),
    .out_rdy      (out_rdy),
    .res_cnt      (res_cnt)
  );

  // Reference grant: scan channels in priority order, first requester wins.
  function automatic int mgrant(input logic [NCH-1:0] v, input logic t, input int p);
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = t ? k : (p + k) % NCH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [NCH-1:0] exp_rdy();
    int g;
    g = mgrant(ch_vld, test_mode_en, mptr);
    if (sys_rst_n && g >= 0 && mq.size() < 2) return NCH'(1 << g);
    return '0;
  endfunction

  // Update the model with the transfers of the coming rising edge, then move
  // on to the following falling edge where the next inputs get driven.
  task automatic advance();
    int   g;
    bit   pop_ok;
    bit   push_ok;
    ent_t e;
    if (!sys_rst_n) begin
      mq.delete();
      mptr = 0;
      mcnt = 0;
    end else begin
      g       = mgrant(ch_vld, test_mode_en, mptr);
      pop_ok  = (mq.size() > 0) && out_rdy;
      push_ok = (g >= 0) && (mq.size() < 2);
      if (pop_ok) begin
        void'(mq.pop_front());
        mcnt = mcnt + 32'd1;
      end
      if (push_ok) begin
        e.id = g[1:0];
        e.d  = ch_data[g*DW +: DW];
        mq.push_back(e);
        if (!test_mode_en) mptr = (g + 1) % NCH;
      end
    end
    @(negedge sys_clk);
  endtask

  task automatic set_a0_data();
    for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = 32'hA0 + i;
  endtask

  task automatic apply_reset();
    sys_rst_n = 1'b0;
    ch_vld    = '0;
    advance();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; test_mode_en = 1'b0; out_rdy = 1'b1; ch_vld = 4'hF;
    set_a0_data();
    advance();
    #1;
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_out_vld got=%0b want=0", out_vld); end
    n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data got=%h want=0", out_data); end
    n_vec++; if (out_ch_id !== 2'd0) begin n_err++; $display("FAIL rst_out_ch_id got=%0d want=0", out_ch_id); end
    n_vec++; if (ch_rdy !== 4'b0000) begin n_err++; $display("FAIL rst_ch_rdy got=%b want=0000", ch_rdy); end
    n_vec++; if (res_cnt !== 32'h0) begin n_err++; $display("FAIL rst_res_cnt got=%0d want=0", res_cnt); end
    ch_vld = '0;
    advance();
    sys_rst_n = 1'b1;
  endtask

  task automatic test_rr_all();
    apply_reset();
    test_mode_en = 1'b0; out_rdy = 1'b1; set_a0_data(); ch_vld = 4'hF;
    #1;
    n_vec++; if (ch_rdy !== 4'b0001) begin n_err++; $display("FAIL rr_first_rdy got=%b want=0001", ch_rdy); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rr_first_vld got=%0b want=0", out_vld); end
    advance();
    for (int k = 0; k < 5; k++) begin
      #1;
      n_vec++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL rr_vld[%0d] got=%0b want=1", k, out_vld); end
      n_vec++; if (out_ch_id !== 2'(k % 4)) begin n_err++; $display("FAIL rr_id[%0d] got=%0d want=%0d", k, out_ch_id, k % 4); end
      n_vec++; if (out_data !== 32'hA0 + (k % 4)) begin n_err++; $display("FAIL rr_data[%0d] got=%h want=%h", k, out_data, 32'hA0 + (k % 4)); end
      advance();
    end
    ch_vld = '0;
    advance(); advance();
  endtask

  task automatic test_backpressure();
    apply_reset();
    test_mode_en = 1'b0; out_rdy = 1'b0; set_a0_data(); ch_vld = 4'b0101;
    #1;
    n_vec++; if (ch_rdy !== 4'b0001) begin n_err++; $display("FAIL bp_rdy0 got=%b want=0001", ch_rdy); end
    advance(); #1;
    n_vec++; if (ch_rdy !== 4'b0100) begin n_err++; $display("FAIL bp_rdy1 got=%b want=0100", ch_rdy); end
    n_vec++; if (out_data !== 32'hA0) begin n_err++; $display("FAIL bp_data1 got=%h want=a0", out_data); end
    advance();
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (ch_rdy !== 4'b0000) begin n_err++; $display("FAIL bp_full_rdy[%0d] got=%b want=0000", k, ch_rdy); end
      n_vec++; if (out_data !== 32'hA0 || out_ch_id !== 2'd0 || out_vld !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d] got=%0b/%0d/%h want=1/0/a0", k, out_vld, out_ch_id, out_data); end
      advance();
    end
    out_rdy = 1'b1; #1;
    n_vec++; if (ch_rdy !== 4'b0000) begin n_err++; $display("FAIL bp_rdy_indep got=%b want=0000", ch_rdy); end
    advance(); #1;
    n_vec++; if (out_data !== 32'hA2 || out_ch_id !== 2'd2) begin n_err++; $display("FAIL bp_second got=%0d/%h want=2/a2", out_ch_id, out_data); end
    n_vec++; if (ch_rdy !== 4'b0001) begin n_err++; $display("FAIL bp_rdy_after got=%b want=0001", ch_rdy); end
    advance();
    ch_vld = '0;
    advance(); advance();
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    test_mode_en = 1'b0; out_rdy = 1'b1; set_a0_data(); ch_vld = 4'b0100;
    advance();
    test_mode_en = 1'b1; ch_vld = 4'b1110;
    #1;
    n_vec++; if (out_ch_id !== 2'd2) begin n_err++; $display("FAIL fp_head got=%0d want=2", out_ch_id); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (ch_rdy !== 4'b0010) begin n_err++; $display("FAIL fp_rdy[%0d] got=%b want=0010", k, ch_rdy); end
      advance();
      if (k == 2) ch_vld = '0;
      #1;
      n_vec++; if (out_ch_id !== 2'd1 || out_vld !== 1'b1) begin n_err++; $display("FAIL fp_id[%0d] got=%0b/%0d want=1/1", k, out_vld, out_ch_id); end
      n_vec++; if (dut.rr_ptr !== 2'd3) begin n_err++; $display("FAIL fp_rr_ptr[%0d] got=%0d want=3", k, dut.rr_ptr); end
    end
    advance();
    test_mode_en = 1'b0; ch_vld = 4'b1110; #1;
    n_vec++; if (ch_rdy !== 4'b1000) begin n_err++; $display("FAIL fp_rr_resume got=%b want=1000", ch_rdy); end
    advance();
    ch_vld = '0;
    advance(); advance();
  endtask

  task automatic test_wrap();
    apply_reset();
    test_mode_en = 1'b0; out_rdy = 1'b1; set_a0_data(); ch_vld = 4'b0100;
    advance();
    ch_vld = 4'b1001; #1;
    n_vec++; if (ch_rdy !== 4'b1000) begin n_err++; $display("FAIL wrap_rdy3 got=%b want=1000", ch_rdy); end
    advance(); #1;
    n_vec++; if (ch_rdy !== 4'b0001) begin n_err++; $display("FAIL wrap_rdy0 got=%b want=0001", ch_rdy); end
    n_vec++; if (out_ch_id !== 2'd3) begin n_err++; $display("FAIL wrap_id3 got=%0d want=3", out_ch_id); end
    advance();
    ch_vld = '0; #1;
    n_vec++; if (out_ch_id !== 2'd0 || out_data !== 32'hA0) begin n_err++; $display("FAIL wrap_id0 got=%0d/%h want=0/a0", out_ch_id, out_data); end
    advance(); #1;
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL wrap_drained got=%0b want=0", out_vld); end
  endtask

  task automatic test_reset_mid();
    test_mode_en = 1'b0; out_rdy = 1'b0; set_a0_data(); ch_vld = 4'hF;
    advance(); advance(); #1;
    n_vec++; if (ch_rdy !== 4'b0000 || out_vld !== 1'b1) begin n_err++; $display("FAIL rm_full got=%b/%0b want=0000/1", ch_rdy, out_vld); end
    sys_rst_n = 1'b0; ch_vld = '0; #1;
    n_vec++; if (out_vld !== 1'b0 || out_data !== 32'h0 || out_ch_id !== 2'd0) begin
      n_err++; $display("FAIL rm_in_reset got=%0b/%0d/%h want=0/0/0", out_vld, out_ch_id, out_data); end
    advance();
    sys_rst_n = 1'b1; out_rdy = 1'b1; #1;
    n_vec++; if (res_cnt !== 32'h0) begin n_err++; $display("FAIL rm_res_cnt got=%0d want=0", res_cnt); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rm_stale[%0d] got=%0b want=0", k, out_vld); end
      advance();
    end
    ch_vld = 4'b0110; #1;
    n_vec++; if (ch_rdy !== 4'b0010) begin n_err++; $display("FAIL rm_grant got=%b want=0010", ch_rdy); end
    advance();
    ch_vld = '0; #1;
    n_vec++; if (out_ch_id !== 2'd1 || out_data !== 32'hA1) begin n_err++; $display("FAIL rm_first got=%0d/%h want=1/a1", out_ch_id, out_data); end
    advance();
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    test_mode_en = 1'b0; out_rdy = 1'b0; set_a0_data(); ch_vld = 4'b0001;
    advance();
    ch_vld = '0;
    force dut.res_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.res_cnt;
    mcnt = 32'hFFFF_FFFF;
    #1;
    n_vec++; if (res_cnt !== mcnt) begin n_err++; $display("FAIL cw_preset got=%h want=%h", res_cnt, mcnt); end
    out_rdy = 1'b1;
    advance(); #1;
    n_vec++; if (res_cnt !== 32'h0) begin n_err++; $display("FAIL cw_wrap got=%h want=0", res_cnt); end
    n_vec++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL cw_drained got=%0b want=0", out_vld); end
  endtask

  task automatic test_random();
    logic [NCH-1:0] er;
    logic           ev;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      sys_rst_n    = ($urandom_range(0, 99) != 0);
      test_mode_en = ($urandom_range(0, 7) == 0);
      ch_vld       = NCH'($urandom);
      out_rdy      = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NCH; i++) ch_data[i*DW +: DW] = $urandom;
      #1;
      er = exp_rdy();
      ev = sys_rst_n && (mq.size() > 0);
      n_vec++; if (ch_rdy !== er) begin n_err++; $display("FAIL rnd_rdy@%0d got=%b want=%b", cyc, ch_rdy, er); end
      n_vec++; if (out_vld !== ev) begin n_err++; $display("FAIL rnd_vld@%0d got=%0b want=%0b", cyc, out_vld, ev); end
      if (ev) begin
        n_vec++; if (out_ch_id !== mq[0].id || out_data !== mq[0].d) begin
          n_err++; $display("FAIL rnd_head@%0d got=%0d/%h want=%0d/%h", cyc, out_ch_id, out_data, mq[0].id, mq[0].d); end
      end
      n_vec++; if (res_cnt !== mcnt) begin n_err++; $display("FAIL rnd_cnt@%0d got=%0d want=%0d", cyc, res_cnt, mcnt); end
      advance();
    end
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst_n = 1'b0; test_mode_en = 1'b0; ch_vld = '0; ch_data = '0; out_rdy = 1'b0;
    test_reset();
    test_rr_all();
    test_backpressure();
    test_fixed_priority();
    test_wrap();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mtx_res_collector.md
MTX_RES_COLLECTOR -- requirements
Module: mtx_res_collector

Interface
REQ-001 Parameter NUM_CH, default 32: number of MAPU result channels collected; legal range 2..64.
REQ-002 Parameter DATA_WIDTH, default 32: width of one result word.
REQ-003 sys_clk  input  1  single clock for all state; one clock domain, and all state is clocked on the rising edge.
REQ-004 sys_rst_n  input  1  reset, synchronous to sys_clk, active-low.
REQ-005 test_mode_en  input  1  1 = fixed priority, channel 0 highest; 0 = round-robin.
REQ-006 ch_vld  input  NUM_CH  per-channel result valid from MAPU instance i.
REQ-007 ch_data  input  NUM_CH*DATA_WIDTH  result words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 ch_rdy  output  NUM_CH  per-channel accept; at most one bit set per cycle.
REQ-009 out_vld  output  1  collected result valid.
REQ-010 out_data  output  DATA_WIDTH  collected result word.
REQ-011 out_ch_id  output  $clog2(NUM_CH)  source channel index of out_data.
REQ-012 out_rdy  input  1  downstream accept.
REQ-013 res_cnt  output  32  total results delivered on the output since reset.

Function
REQ-014 A transfer occurs on a channel when ch_vld[i] && ch_rdy[i] at a rising edge; on the output when out_vld && out_rdy.
REQ-015 The block buffers {ch_id, data} in a 2-entry FIFO; an input transfer in cycle N appears at the FIFO head, with out_vld=1, in cycle N+1 at the earliest.
REQ-016 ch_rdy[i]=1 only when FIFO count<2 and channel i holds the grant; ch_rdy has no combinational dependence on out_rdy.
REQ-017 Round-robin grant goes to the first channel with ch_vld set, searching upward from rr_ptr and wrapping at NUM_CH-1 to 0.
REQ-018 On each input transfer from channel g, rr_ptr becomes (g+1) mod NUM_CH; otherwise rr_ptr holds.
REQ-019 When test_mode_en=1, grant goes to the lowest-index channel with ch_vld set, and rr_ptr holds.
REQ-020 When no ch_vld bit is set, or the FIFO is full, all ch_rdy bits are 0.
REQ-021 A simultaneous push and pop with count=1 leaves count=1 and sustains one result per cycle.
REQ-022 A simultaneous push and pop with count=2 is impossible, because of REQ-016; the pop alone reduces count to 1.
REQ-023 out_vld, out_data and out_ch_id hold stable while out_vld=1 and out_rdy=0.
REQ-024 Output order equals acceptance order; no result is dropped or duplicated.
REQ-025 res_cnt increments by 1 on each output transfer and wraps from 0xFFFF_FFFF to 0.
REQ-026 A ch_vld deassertion without a transfer is tolerated, and the grant is recomputed each cycle.

Reset
REQ-027 While sys_rst_n=0 at a clock edge, the FIFO empties (count=0), rr_ptr=0 and res_cnt=0.
REQ-028 During reset, outputs are out_vld=0, out_data=0, out_ch_id=0 and ch_rdy=0.
REQ-029 Reset asserted mid-operation discards all buffered results; the first post-reset grant follows REQ-017 from rr_ptr=0.

Structure
REQ-030 The shared package mtx_pkg holds:
- MTX_NUM_CH_DEFAULT and MTX_DATA_WIDTH_DEFAULT constants;
- a typedef for the channel-id type;
- a typedef for the packed FIFO entry struct {ch_id, data}.
REQ-031 The 2-entry FIFO is the sub-module mtx_res_fifo, parameterised on entry width, with push/pop/full/empty ports.
REQ-032 The arbiter and rr_ptr logic are implemented inline in mtx_res_collector.
REQ-033 The block instantiates in mtx_top between the MAPU instances' result outputs and the sub-system result port.

Verification (bench NUM_CH=4, DATA_WIDTH=32)
REQ-034 Reset then ch_vld=4'b1111, with data=0xA0+i, and out_rdy=1 -> outputs ch 0,1,2,3,0 in consecutive cycles; first out_vld appears 1 cycle after the first accept.
REQ-035 out_rdy=0 with ch_vld=4'b0101 -> ch0 and ch2 accepted; ch_rdy then 0; out_data holds 0xA0 until out_rdy=1.
REQ-036 test_mode_en=1, ch_vld=4'b1110 for 3 transfers -> out_ch_id 1,1,1; rr_ptr unchanged.
REQ-037 rr_ptr=3 (last grant ch2), ch_vld=4'b1001 -> ch3 granted, then ch0 (wrap).
REQ-038 FIFO full, then sys_rst_n=0 for 1 cycle -> out_vld=0, res_cnt=0; the buffered results never appear on the output.
REQ-039 res_cnt forced to 0xFFFF_FFFF, then one output transfer -> res_cnt=0.
